hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the 5-stage CPU. It keeps a shadow scoreboard of destination registers in EX, MEM and WB and produces the forwarding selects for the EX-stage ALU operand muxes. It also generates the load-use stall/bubble, the branch-taken flush, and the HLT drain/halt sequence. It sits beside the ID stage; the IF/ID and ID/EX pipeline registers consume its outputs.

---
 rtl/hazard_pkg.sv | 44 ++++
 rtl/hazard_sb.sv | 66 ++++++
 rtl/hazard_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller.
//               Defines the controller state encoding, the forwarding-select
//               encoding, the scoreboard entry layout, and the source-hit
//               helper used by the scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Width of the rd field held in each scoreboard entry. This is the
    // architectural register-specifier width and must match REG_W on
    // hazard_ctrl.
    localparam int SB_RD_W = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic               valid;
        logic               wr;
        logic               load;
        logic [SB_RD_W-1:0] rd;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // R0 is hard-wired to zero, so a dependency on it is never a hazard.
    function automatic logic sb_hit(input sb_entry_t e,
                                    input logic [SB_RD_W-1:0] src,
                                    input logic uses);
        return e.valid && e.wr && (e.rd == src) && (src != '0) && uses;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_sb.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sb
// Description : Three-entry shadow scoreboard (EX, MEM, WB) of in-flight
//               destination registers, with combinational hit queries for
//               the two source operands of the instruction in ID.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_capture       - load i_entry into the EX slot this edge
//               i_entry         - ID instruction's {valid, wr, load, rd}
//               i_rs/i_rt       - ID source registers to query
//               i_uses_rs/_rt   - qualifies each source query
//               o_ex_hit_*      - source matches the EX-slot producer
//               o_ex_load       - EX-slot producer is a load
//               o_mem_hit_*     - source matches the MEM-slot producer
//               o_empty         - no valid entry in any slot
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sb
    import hazard_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_capture,
    input  sb_entry_t          i_entry,
    input  logic [SB_RD_W-1:0] i_rs,
    input  logic [SB_RD_W-1:0] i_rt,
    input  logic               i_uses_rs,
    input  logic               i_uses_rt,
    output logic               o_ex_hit_rs,
    output logic               o_ex_hit_rt,
    output logic               o_ex_load,
    output logic               o_mem_hit_rs,
    output logic               o_mem_hit_rt,
    output logic               o_empty
);

    sb_entry_t r_ex_q;
    sb_entry_t r_mem_q;
    sb_entry_t r_wb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_q  <= SB_EMPTY;
            r_mem_q <= SB_EMPTY;
            r_wb_q  <= SB_EMPTY;
        end else begin
            r_wb_q  <= r_mem_q;
            r_mem_q <= r_ex_q;
            r_ex_q  <= i_capture ? i_entry : SB_EMPTY;
        end
    end

    assign o_ex_hit_rs  = sb_hit(r_ex_q,  i_rs, i_uses_rs);
    assign o_ex_hit_rt  = sb_hit(r_ex_q,  i_rt, i_uses_rt);
    assign o_mem_hit_rs = sb_hit(r_mem_q, i_rs, i_uses_rs);
    assign o_mem_hit_rt = sb_hit(r_mem_q, i_rt, i_uses_rt);
    assign o_ex_load    = r_ex_q.load;
    assign o_empty      = !(r_ex_q.valid || r_mem_q.valid || r_wb_q.valid);

    // The WB slot only matters for drain detection: the register file
    // bypasses same-cycle write-back, so WB never forwards.
    logic w_unused_fields;
    assign w_unused_fields = ^{r_mem_q.load, r_wb_q.wr, r_wb_q.load, r_wb_q.rd};

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard and sequencing controller for the 5-stage
//               CPU. Produces EX-stage forwarding selects, the load-use
//               stall/bubble, the branch-taken flush and the HLT drain/halt
//               sequence.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               id_*                   - decoded fields of the ID instruction
//               ex_branch_taken        - taken branch/call resolved in EX
//               stall_pc, bubble_ex    - hold PC + IF/ID, insert NOP in ID/EX
//               flush                  - squash IF/ID and ID/EX
//               fwd_a, fwd_b           - ALU operand selects for EX
//               halted                 - pipeline drained after HLT
//               stall_cnt, flush_cnt   - saturating event counters
//                                        (only with HAZARD_STATS_EN)
// Options     : HAZARD_STATS_EN - adds the statistics counters and ports
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W = 4
`ifdef HAZARD_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             id_hlt,
    input  logic             ex_branch_taken,
    output logic             stall_pc,
    output logic             bubble_ex,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
`ifdef HAZARD_STATS_EN
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt,
`endif
    output logic             halted
);

    state_t    r_state;
    state_t    w_state_nxt;
    sb_entry_t w_entry;
    logic      w_capture;
    logic      w_load_use;
    logic      w_ex_hit_rs, w_ex_hit_rt, w_ex_load;
    logic      w_mem_hit_rs, w_mem_hit_rt, w_sb_empty;
    logic [1:0] w_fwd_a, w_fwd_b;
    logic [1:0] r_fwd_a, r_fwd_b;

    assign w_entry = '{valid: 1'b1, wr: id_wr, load: id_load, rd: id_rd};

    // A bubble or flush must not capture the ID instruction; an HLT never
    // enters the scoreboard so that the drain can complete.
    assign w_capture = (r_state == RUN) && id_valid && !id_hlt && !stall_pc && !flush;

    hazard_sb u_sb (
        .clk          (clk),
        .rst          (rst),
        .i_capture    (w_capture),
        .i_entry      (w_entry),
        .i_rs         (id_rs),
        .i_rt         (id_rt),
        .i_uses_rs    (id_valid && id_uses_rs),
        .i_uses_rt    (id_valid && id_uses_rt),
        .o_ex_hit_rs  (w_ex_hit_rs),
        .o_ex_hit_rt  (w_ex_hit_rt),
        .o_ex_load    (w_ex_load),
        .o_mem_hit_rs (w_mem_hit_rs),
        .o_mem_hit_rt (w_mem_hit_rt),
        .o_empty      (w_sb_empty)
    );

    assign w_load_use = w_ex_load && (w_ex_hit_rs || w_ex_hit_rt);

    // Youngest producer wins: EX/MEM result over MEM/WB data.
    assign w_fwd_a = (w_ex_hit_rs && !w_ex_load) ? FWD_EXMEM :
                     w_mem_hit_rs                ? FWD_MEMWB : FWD_RF;
    assign w_fwd_b = (w_ex_hit_rt && !w_ex_load) ? FWD_EXMEM :
                     w_mem_hit_rt                ? FWD_MEMWB : FWD_RF;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        flush       = ex_branch_taken;
        stall_pc    = 1'b0;
        bubble_ex   = 1'b0;
        halted      = 1'b0;
        case (r_state)
            RUN: begin
                stall_pc  = w_load_use && !ex_branch_taken;
                bubble_ex = w_load_use && !ex_branch_taken;
                // An HLT behind a taken branch is on the wrong path.
                if (id_valid && id_hlt && !w_load_use && !ex_branch_taken) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                stall_pc  = !ex_branch_taken;
                bubble_ex = !ex_branch_taken;
                if (ex_branch_taken) begin
                    w_state_nxt = RUN;
                end else if (w_sb_empty) begin
                    w_state_nxt = HALTED;
                end
            end
            HALTED: begin
                stall_pc  = 1'b1;
                bubble_ex = 1'b1;
                halted    = 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bubble_ex || flush) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else begin
            r_fwd_a <= w_fwd_a;
            r_fwd_b <= w_fwd_b;
        end
    end

    assign fwd_a = r_fwd_a;
    assign fwd_b = r_fwd_b;

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] r_stall_cnt;
    logic [STAT_W-1:0] r_flush_cnt;
    localparam logic [STAT_W-1:0] c_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    // Only load-use stalls count; DRAIN/HALTED hold the PC for other reasons.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((r_state == RUN) && stall_pc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_ONE;
            end
            if (flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_ONE;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire
